// File: rtl/sonar_rx_decoder.sv
// sonar_rx_decoder: receives the sonar serial stream and recovers
// "AAA,DDD#" measurement packets. The angle and distance come out as
// 3-digit BCD words, with a one-cycle pronto pulse per accepted packet.
// Frame: 1 start bit, DATA_BITS data bits LSB first, even parity, 2 stop bits.
// Optional build macro: PARITY_CHECK_EN
//   defined   -> a parity mismatch invalidates the character
//   undefined -> the parity bit time is spent and its value is ignored
module sonar_rx_decoder #(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_BITS = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx_serial,
   output logic [11:0] angulo,
   output logic [11:0] distancia,
   output logic        pronto,
   output logic        erro_pacote,
   output logic [3:0]  db_estado
);

   localparam int CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int HALF = BAUD_DIV / 2;

   typedef enum logic [3:0] {
      INICIAL  = 4'd0,
      START    = 4'd1,
      DADOS    = 4'd2,
      PARIDADE = 4'd3,
      STOP     = 4'd4,
      ENTREGA  = 4'd5
   } bitState_t;

   bitState_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bitIdx_q, bitIdx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 frameErr_q, frameErr_d;
   logic                 sync1_q, sync2_q, rxPrev_q;
   logic                 rxS;
   logic                 bitFull;
   logic                 parityErr;

`ifdef PARITY_CHECK_EN
   logic                 parity_q, parity_d;
`endif

   assign rxS     = sync2_q;
   assign bitFull = (cnt_q == CW'(BAUD_DIV - 1));

   // Synchronizer, edge history and bit-level receive registers
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxPrev_q   <= 1'b1;
         state_q    <= INICIAL;
         cnt_q      <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         frameErr_q <= 1'b0;
`ifdef PARITY_CHECK_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         sync1_q    <= rx_serial;
         sync2_q    <= sync1_q;
         rxPrev_q   <= sync2_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitIdx_q   <= bitIdx_d;
         shift_q    <= shift_d;
         frameErr_q <= frameErr_d;
`ifdef PARITY_CHECK_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // Bit FSM: find the start edge, sample every bit at mid-bit, hand the character over
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bitIdx_d   = bitIdx_q;
      shift_d    = shift_q;
      frameErr_d = frameErr_q;
`ifdef PARITY_CHECK_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         INICIAL: begin
            cnt_d    = '0;
            bitIdx_d = '0;
            if (rxPrev_q && !rxS) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CW'(HALF - 1)) begin
               cnt_d   = '0;
               state_d = rxS ? INICIAL : DADOS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DADOS: begin
            if (bitFull) begin
               cnt_d   = '0;
               shift_d = {rxS, shift_q[DATA_BITS-1:1]};
               if (bitIdx_q == BW'(DATA_BITS - 1)) begin
                  state_d = PARIDADE;
               end else begin
                  bitIdx_d = bitIdx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PARIDADE: begin
            if (bitFull) begin
               cnt_d   = '0;
`ifdef PARITY_CHECK_EN
               parity_d = rxS;
`endif
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bitFull) begin
               cnt_d      = '0;
               frameErr_d = !rxS;
               state_d    = ENTREGA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ENTREGA: begin
            state_d = INICIAL;
         end
         default: begin
            state_d = INICIAL;
         end
      endcase
   end

`ifdef PARITY_CHECK_EN
   assign parityErr = ^{shift_q, parity_q};
`else
   assign parityErr = 1'b0;
`endif

   // Packet parser state
   logic [2:0]  index_q, index_d;
   logic        resync_q, resync_d;
   logic [11:0] angSh_q, angSh_d;
   logic [11:0] distSh_q, distSh_d;
   logic [11:0] angulo_q, angulo_d;
   logic [11:0] distancia_q, distancia_d;
   logic        pronto_q, pronto_d;
   logic        erro_q, erro_d;

   logic        charStrobe;
   logic        charBad;
   logic [7:0]  charWide;
   logic [3:0]  nib;
   logic        isDigit, isComma, isHash, classOk;

   assign charStrobe = (state_q == ENTREGA);
   assign charBad    = frameErr_q | parityErr;
   assign charWide   = 8'(shift_q);
   assign nib        = charWide[3:0];
   assign isDigit    = (charWide >= 8'h30) && (charWide <= 8'h39);
   assign isComma    = (charWide == 8'h2C);
   assign isHash     = (charWide == 8'h23);

   // Character class expected at the current packet position
   always_comb begin
      classOk = 1'b0;
      case (index_q)
         3'd3:    classOk = isComma;
         3'd7:    classOk = isHash;
         default: classOk = isDigit;
      endcase
   end

   // Parser registers: shadow digits, published outputs and status pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         index_q     <= '0;
         resync_q    <= 1'b0;
         angSh_q     <= '0;
         distSh_q    <= '0;
         angulo_q    <= '0;
         distancia_q <= '0;
         pronto_q    <= 1'b0;
         erro_q      <= 1'b0;
      end else begin
         index_q     <= index_d;
         resync_q    <= resync_d;
         angSh_q     <= angSh_d;
         distSh_q    <= distSh_d;
         angulo_q    <= angulo_d;
         distancia_q <= distancia_d;
         pronto_q    <= pronto_d;
         erro_q      <= erro_d;
      end
   end

   // Parser next state: collect digits, publish on '#', drop bad packets and resync on '#'
   always_comb begin
      index_d     = index_q;
      resync_d    = resync_q;
      angSh_d     = angSh_q;
      distSh_d    = distSh_q;
      angulo_d    = angulo_q;
      distancia_d = distancia_q;
      pronto_d    = 1'b0;
      erro_d      = 1'b0;
      if (charStrobe) begin
         if (resync_q) begin
            if (!charBad && isHash) begin
               resync_d = 1'b0;
               index_d  = '0;
            end
         end else if (!charBad && classOk) begin
            case (index_q)
               3'd0:    angSh_d[11:8]  = nib;
               3'd1:    angSh_d[7:4]   = nib;
               3'd2:    angSh_d[3:0]   = nib;
               3'd4:    distSh_d[11:8] = nib;
               3'd5:    distSh_d[7:4]  = nib;
               3'd6:    distSh_d[3:0]  = nib;
               default: ;
            endcase
            if (index_q == 3'd7) begin
               angulo_d    = angSh_q;
               distancia_d = distSh_q;
               pronto_d    = 1'b1;
               index_d     = '0;
            end else begin
               index_d = index_q + 1'b1;
            end
         end else begin
            erro_d  = 1'b1;
            index_d = '0;
            if (charBad || !isHash) begin
               resync_d = 1'b1;
            end
         end
      end
   end

   assign angulo      = angulo_q;
   assign distancia   = distancia_q;
   assign pronto      = pronto_q;
   assign erro_pacote = erro_q;
   assign db_estado   = state_q;

endmodule

// File: tb/tb_sonar_rx_decoder.sv
// tb_sonar_rx_decoder: drives serial packets into sonar_rx_decoder at BAUD_DIV = 8.
// Expected packets are queued as they are sent; received packets are compared after each scenario.
// Honours PARITY_CHECK_EN in the parity scenario.
module tb_sonar_rx_decoder;

   localparam int BD = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_serial;
   logic [11:0] angulo;
   logic [11:0] distancia;
   logic        pronto;
   logic        erro_pacote;
   logic [3:0]  db_estado;

   int total = 0;
   int bad = 0;
   int errSeen = 0;
   int bothSeen = 0;
   logic [23:0] gotQ[$];
   logic [23:0] expQ[$];

   sonar_rx_decoder #(.BAUD_DIV(BD), .DATA_BITS(7)) dut (
      .clock(clock),
      .reset(reset),
      .rx_serial(rx_serial),
      .angulo(angulo),
      .distancia(distancia),
      .pronto(pronto),
      .erro_pacote(erro_pacote),
      .db_estado(db_estado)
   );

   // Free-running clock
   always #5 clock = ~clock;

   // Monitor: collect accepted packets and error pulses away from the active edge
   always @(negedge clock) begin
      if (reset !== 1'b1) begin
         if (pronto === 1'b1) gotQ.push_back({angulo, distancia});
         if (erro_pacote === 1'b1) errSeen++;
         if (pronto === 1'b1 && erro_pacote === 1'b1) bothSeen++;
      end
   end

   task automatic idleBits(input int n);
      rx_serial = 1'b1;
      repeat (n * BD) @(negedge clock);
   endtask

   task automatic sendChar(input logic [7:0] c, input bit flipPar, input bit badStop);
      logic [6:0] d;
      logic p;
      d = c[6:0];
      p = (^d) ^ flipPar;
      rx_serial = 1'b0;
      repeat (BD) @(negedge clock);
      for (int i = 0; i < 7; i++) begin
         rx_serial = d[i];
         repeat (BD) @(negedge clock);
      end
      rx_serial = p;
      repeat (BD) @(negedge clock);
      rx_serial = !badStop;
      repeat (BD) @(negedge clock);
      rx_serial = 1'b1;
      repeat (BD) @(negedge clock);
   endtask

   task automatic applyStimulus(input string s, input int flipIdx, input int badStopIdx);
      for (int i = 0; i < s.len(); i++) begin
         sendChar(s[i], (i == flipIdx), (i == badStopIdx));
      end
      idleBits(3);
   endtask

   task automatic test_reset;
      total++; if (angulo !== 12'h000) begin bad++; $display("[TB] FAIL reset_angulo got=%h want=000", angulo); end
      total++; if (distancia !== 12'h000) begin bad++; $display("[TB] FAIL reset_distancia got=%h want=000", distancia); end
      total++; if (pronto !== 1'b0) begin bad++; $display("[TB] FAIL reset_pronto got=%b want=0", pronto); end
      total++; if (erro_pacote !== 1'b0) begin bad++; $display("[TB] FAIL reset_erro got=%b want=0", erro_pacote); end
      total++; if (db_estado !== 4'd0) begin bad++; $display("[TB] FAIL reset_estado got=%0d want=0", db_estado); end
   endtask

   task automatic test_basic;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      expQ.push_back({12'h090, 12'h025});
      applyStimulus("090,025#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL basic_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL basic_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 0) begin bad++; $display("[TB] FAIL basic_errors got=%0d want=0", errSeen - errBase); end
   endtask

   task automatic test_glitch;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      rx_serial = 1'b0;
      repeat (3) @(negedge clock);
      idleBits(2);
      total++; if (db_estado !== 4'd0) begin bad++; $display("[TB] FAIL glitch_estado got=%0d want=0", db_estado); end
      expQ.push_back({12'h180, 12'h310});
      applyStimulus("180,310#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL glitch_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL glitch_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 0) begin bad++; $display("[TB] FAIL glitch_errors got=%0d want=0", errSeen - errBase); end
   endtask

   task automatic test_bad_char;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      applyStimulus("09A,025#", -1, -1);
      total++; if ({angulo, distancia} !== {12'h180, 12'h310}) begin bad++; $display("[TB] FAIL badchar_hold got=%h want=180310", {angulo, distancia}); end
      expQ.push_back({12'h045, 12'h100});
      applyStimulus("045,100#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL badchar_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL badchar_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 1) begin bad++; $display("[TB] FAIL badchar_errors got=%0d want=1", errSeen - errBase); end
   endtask

   task automatic test_reset_mid;
      int errBase;
      logic [23:0] e, g;
      applyStimulus("120,0", -1, -1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      total++; if ({angulo, distancia} !== 24'h0) begin bad++; $display("[TB] FAIL midreset_clear got=%h want=000000", {angulo, distancia}); end
      errBase = errSeen;
      gotQ.delete();
      expQ.push_back({12'h020, 12'h040});
      applyStimulus("020,040#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL midreset_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL midreset_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 0) begin bad++; $display("[TB] FAIL midreset_errors got=%0d want=0", errSeen - errBase); end
   endtask

   task automatic test_framing;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      applyStimulus("030,050#", -1, 3);
      total++; if (gotQ.size() !== 0) begin bad++; $display("[TB] FAIL framing_nopronto got=%0d want=0", gotQ.size()); end
      gotQ.delete();
      expQ.push_back({12'h060, 12'h070});
      applyStimulus("060,070#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL framing_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL framing_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 1) begin bad++; $display("[TB] FAIL framing_errors got=%0d want=1", errSeen - errBase); end
   endtask

   task automatic test_parity;
      int errBase;
      int wantErr;
      logic [23:0] e, g;
      errBase = errSeen;
`ifdef PARITY_CHECK_EN
      wantErr = 1;
      applyStimulus("150,015#", 1, -1);
      total++; if ({angulo, distancia} !== {12'h060, 12'h070}) begin bad++; $display("[TB] FAIL parity_hold got=%h want=060070", {angulo, distancia}); end
`else
      wantErr = 0;
      expQ.push_back({12'h150, 12'h015});
      applyStimulus("150,015#", 1, -1);
`endif
      expQ.push_back({12'h222, 12'h333});
      applyStimulus("222,333#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL parity_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL parity_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== wantErr) begin bad++; $display("[TB] FAIL parity_errors got=%0d want=%0d", errSeen - errBase, wantErr); end
   endtask

   task automatic test_hash_resync;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      expQ.push_back({12'h345, 12'h678});
      applyStimulus("12#345,678#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL hash_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL hash_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 1) begin bad++; $display("[TB] FAIL hash_errors got=%0d want=1", errSeen - errBase); end
   endtask

   task automatic test_break;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      rx_serial = 1'b0;
      repeat (30 * BD) @(negedge clock);
      total++; if (db_estado !== 4'd0) begin bad++; $display("[TB] FAIL break_estado got=%0d want=0", db_estado); end
      total++; if (errSeen - errBase !== 1) begin bad++; $display("[TB] FAIL break_single_error got=%0d want=1", errSeen - errBase); end
      idleBits(2);
      expQ.push_back({12'h001, 12'h002});
      applyStimulus("#001,002#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL break_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL break_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 1) begin bad++; $display("[TB] FAIL break_errors got=%0d want=1", errSeen - errBase); end
   endtask

   task automatic test_back_to_back;
      int errBase;
      logic [23:0] e, g;
      errBase = errSeen;
      expQ.push_back({12'h999, 12'h000});
      expQ.push_back({12'h123, 12'h456});
      applyStimulus("999,000#123,456#", -1, -1);
      total++; if (gotQ.size() !== expQ.size()) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=%0d", gotQ.size(), expQ.size()); end
      while (expQ.size() > 0 && gotQ.size() > 0) begin
         e = expQ.pop_front(); g = gotQ.pop_front();
         total++; if (g !== e) begin bad++; $display("[TB] FAIL b2b_value got=%h want=%h", g, e); end
      end
      expQ.delete(); gotQ.delete();
      total++; if (errSeen - errBase !== 0) begin bad++; $display("[TB] FAIL b2b_errors got=%0d want=0", errSeen - errBase); end
      total++; if (bothSeen !== 0) begin bad++; $display("[TB] FAIL pronto_erro_overlap got=%0d want=0", bothSeen); end
   endtask

   // Test sequence
   initial begin
      reset = 1'b1;
      rx_serial = 1'b1;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      test_reset();
      idleBits(1);
      test_basic();
      test_glitch();
      test_bad_char();
      test_reset_mid();
      test_framing();
      test_parity();
      test_hash_resync();
      test_break();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sonar_rx_decoder.md
Name: sonar_rx_decoder

Overview:
Downstream stage of the sonar top level. It receives the serial stream on the sonar's serial output and recovers each measurement packet. Each packet is 8 ASCII characters: angle (3 digits), ',', distance (3 digits), '#'. It presents the angle and distance as 3-digit BCD words with a one-cycle valid pulse, so a receiving board or the test bench can check sonar output without a PC.

Parameters:
BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); must be >= 4
DATA_BITS, 7, data bits per character, LSB first

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_serial  input  1  serial line, idle high
angulo  output  12  BCD angle {centena, dezena, unidade}
distancia  output  12  BCD distance {centena, dezena, unidade}
pronto  output  1  one-cycle pulse: new packet accepted
erro_pacote  output  1  one-cycle pulse: packet discarded
db_estado  output  4  receive-FSM state, for debug

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: angulo = 0, distancia = 0, pronto = 0, erro_pacote = 0, char index = 0, both FSMs idle. Reset mid-character or mid-packet drops all partial data.
- rx_serial passes through a 2-FF synchronizer before use. This adds 2 cycles of latency.
- Character frame: 1 start bit (0), DATA_BITS data bits LSB first, 1 even-parity bit, 2 stop bits (1).
- Bit FSM states (db_estado encoding):
  - INICIAL (0): wait for a synced falling edge.
  - START (1): count BAUD_DIV/2 cycles, then resample. If the line is high, treat it as a glitch and return to INICIAL with no error.
  - DADOS (2): sample each bit every BAUD_DIV cycles at mid-bit.
  - PARIDADE (3): sample the parity bit.
  - STOP (4): sample the first stop bit. If it is 0, raise a framing error: the character is invalid.
  - ENTREGA (5): deliver the character to the parser for one cycle, then go to INICIAL. The second stop bit is not checked; it is absorbed by the next idle wait.
- Packet parser: char index 0..7 with expected classes D D D ',' D D D '#'. D means ASCII '0'..'9' (0x30..0x39).
- Digit value is char[3:0]. Digits go into a shadow register; outputs are not touched until the packet completes.
- On '#' at index 7: copy both shadow words to angulo and distancia in the same cycle, pulse pronto in that cycle, set index = 0. Latency from the mid-sample of the first stop bit of '#' to pronto is 2 cycles.
- Invalid character (wrong class, or framing error) at any index:
  - pulse erro_pacote and leave outputs unchanged;
  - if the bad character is '#', set index = 0 (resync immediately);
  - otherwise enter RESYNC and discard characters until a '#' is received, then set index = 0.
- Each dropped packet pulses erro_pacote exactly once, including framing errors during RESYNC.
- pronto and erro_pacote never assert in the same cycle.
- The line held low for a long time (break) produces a framing error and no further characters until the line returns high.

Optional Feature:
PARITY_CHECK_EN
- Defined: a parity mismatch marks the character invalid and is handled like a framing error (erro_pacote, RESYNC).
- Undefined: the parity bit is sampled and ignored; there is no parity logic beyond sampling.

Test Plan:
1. Send "090,025#" at BAUD_DIV = 8 -> angulo = 0x090, distancia = 0x025, pronto high for exactly 1 cycle, erro_pacote stays 0.
2. Hold rx low for 3 cycles, then high (glitch), then send "180,310#" -> no error; angulo = 0x180, distancia = 0x310.
3. Send "09A,025#" then "045,100#" -> one erro_pacote pulse, outputs unchanged after the first packet; second packet gives angulo = 0x045, distancia = 0x100.
4. Send "120,0", then assert reset for 1 cycle, then "020,040#" -> outputs 0 after reset, then angulo = 0x020, distancia = 0x040, single pronto.
5. Force the first stop bit to 0 on ',' in "030,050#" -> erro_pacote once, no pronto; the next valid "060,070#" is accepted.
6. With PARITY_CHECK_EN defined, flip the parity bit of '5' in "150,015#" -> erro_pacote, no update. Without the macro, the same stimulus gives angulo = 0x150, distancia = 0x015.
